// File: rtl/dice_turn_controller_if.sv
// Board-side signal bundle for the dice turn controller: the player buttons and
// the roller's throw value go in, and the roller enable and game status come out.
interface dice_turn_controller_if #(
    parameter int SCORE_W = 6
);
    logic               btn_a;
    logic               btn_b;
    logic [2:0]         throw_in;
    logic               roll_en;
    logic               turn;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;
    logic [2:0]         last_throw;
    logic               result_valid;
    logic               winner_valid;
    logic               winner;

    modport master (
        output btn_a, btn_b, throw_in,
        input  roll_en, turn, score_a, score_b, last_throw,
               result_valid, winner_valid, winner
    );

    modport slave (
        input  btn_a, btn_b, throw_in,
        output roll_en, turn, score_a, score_b, last_throw,
               result_valid, winner_valid, winner
    );
endinterface

// File: rtl/dice_turn_controller.sv
// Two-player turn sequencer sharing one dice roller between players A and B.
// The current player's button gates the roller for at least MIN_ROLL cycles.
// A settled valid throw is added to that player's score, and the turn passes to
// the other player. Reaching TARGET ends the game until reset.
module dice_turn_controller #(
    parameter int SCORE_W  = 6,
    parameter int TARGET   = 30,
    parameter int MIN_ROLL = 8
) (
    input logic                   clk,
    input logic                   rst,
    dice_turn_controller_if.slave bus
);
    localparam int CNT_W = $clog2(MIN_ROLL + 1);

    typedef enum logic [1:0] {IDLE, ROLL, CAPTURE, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               turn_q, turn_d;
    logic               armed_q, armed_d;
    logic [SCORE_W-1:0] score_a_q, score_a_d;
    logic [SCORE_W-1:0] score_b_q, score_b_d;
    logic [2:0]         last_throw_q, last_throw_d;
    logic               result_valid_q, result_valid_d;
    logic               winner_valid_q, winner_valid_d;
    logic               winner_q, winner_d;

    logic               btn_cur;
    logic               throw_ok;
    logic [SCORE_W-1:0] score_cur;
    logic [SCORE_W-1:0] score_new;

    // Only the current player's button matters. 0 and 7 are not dice faces.
    assign btn_cur   = turn_q ? bus.btn_b : bus.btn_a;
    assign throw_ok  = (bus.throw_in != 3'd0) && (bus.throw_in != 3'd7);
    assign score_cur = turn_q ? score_b_q : score_a_q;
    assign score_new = score_cur + SCORE_W'(bus.throw_in);

    // Registered game state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            turn_q         <= 1'b0;
            armed_q        <= 1'b0;
            score_a_q      <= '0;
            score_b_q      <= '0;
            last_throw_q   <= 3'd0;
            result_valid_q <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            turn_q         <= turn_d;
            armed_q        <= armed_d;
            score_a_q      <= score_a_d;
            score_b_q      <= score_b_d;
            last_throw_q   <= last_throw_d;
            result_valid_q <= result_valid_d;
            winner_valid_q <= winner_valid_d;
            winner_q       <= winner_d;
        end
    end

    // Turn sequencing: arm on a released button, roll, capture, score, hand over
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        turn_d         = turn_q;
        armed_d        = armed_q;
        score_a_d      = score_a_q;
        score_b_d      = score_b_q;
        last_throw_d   = last_throw_q;
        result_valid_d = 1'b0;
        winner_valid_d = winner_valid_q;
        winner_d       = winner_q;

        case (state_q)
            IDLE: begin
                if (!btn_cur) begin
                    armed_d = 1'b1;
                end
                if (armed_q && btn_cur) begin
                    state_d = ROLL;
                    cnt_d   = '0;
                end
            end
            ROLL: begin
                if (cnt_q != CNT_W'(MIN_ROLL)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if ((cnt_q >= CNT_W'(MIN_ROLL - 1)) && !btn_cur) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!throw_ok) begin
                    state_d = ROLL;
                    cnt_d   = '0;
                end else begin
                    last_throw_d   = bus.throw_in;
                    result_valid_d = 1'b1;
                    if (turn_q) begin
                        score_b_d = score_new;
                    end else begin
                        score_a_d = score_new;
                    end
                    if (score_new >= SCORE_W'(TARGET)) begin
                        state_d        = DONE;
                        winner_d       = turn_q;
                        winner_valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        turn_d  = ~turn_q;
                        armed_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.roll_en      = (state_q == ROLL);
    assign bus.turn         = turn_q;
    assign bus.score_a      = score_a_q;
    assign bus.score_b      = score_b_q;
    assign bus.last_throw   = last_throw_q;
    assign bus.result_valid = result_valid_q;
    assign bus.winner_valid = winner_valid_q;
    assign bus.winner       = winner_q;
endmodule

// File: tb/tb_dice_turn_controller.sv
// Randomized bench for dice_turn_controller. The model tracks only the game:
// the scores, whose turn it is, and the winner. The expected roll length is
// max(MIN_ROLL, hold length).
module tb_dice_turn_controller;
    localparam int SCORE_W  = 6;
    localparam int TARGET   = 30;
    localparam int MIN_ROLL = 8;

    logic clk = 1'b0;
    logic rst;

    dice_turn_controller_if #(.SCORE_W(SCORE_W)) bus ();

    dice_turn_controller #(
        .SCORE_W (SCORE_W),
        .TARGET  (TARGET),
        .MIN_ROLL(MIN_ROLL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   mScore[2];
    logic mTurn;
    logic mDone;
    logic mWinner;
    int   mLast;
    logic nextHeld;
    int   nextPre;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setButtons(input logic cur, input logic other);
        if (mTurn == 1'b0) begin
            bus.btn_a = cur;
            bus.btn_b = other;
        end else begin
            bus.btn_b = cur;
            bus.btn_a = other;
        end
    endtask

    task automatic modelReset();
        mScore[0] = 0;
        mScore[1] = 0;
        mTurn     = 1'b0;
        mDone     = 1'b0;
        mWinner   = 1'b0;
        mLast     = 0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_score_a"}, int'(bus.score_a), mScore[0]);
        checkOutput({tag, "_score_b"}, int'(bus.score_b), mScore[1]);
        checkOutput({tag, "_turn"}, int'(bus.turn), int'(mTurn));
        checkOutput({tag, "_last_throw"}, int'(bus.last_throw), mLast);
        checkOutput({tag, "_winner_valid"}, int'(bus.winner_valid), int'(mDone));
        checkOutput({tag, "_winner"}, int'(bus.winner), int'(mWinner));
    endtask

    // Reset with btn_a held high; afterwards the model and the DUT are both in a fresh game
    task automatic resetDut();
        rst       = 1'b1;
        bus.btn_a = 1'b1;
        bus.btn_b = 1'(($urandom_range(1)));
        step();
        rst = 1'b0;
        modelReset();
        checkOutput("reset_roll_en", int'(bus.roll_en), 0);
        checkOutput("reset_result_valid", int'(bus.result_valid), 0);
        checkState("reset");
        bus.btn_a = 1'b1;
        step();
    endtask

    // One complete turn: optional held button, arm, press, roll, capture (with possible re-rolls)
    task automatic applyStimulus(input int holdLen, input int preHold);
        int   len;
        int   hl;
        int   attempts;
        int   v;
        logic rolling;

        for (int p = 0; p < preHold; p++) begin
            checkOutput("held_no_roll", int'(bus.roll_en), 0);
            setButtons(1'b1, 1'(($urandom_range(1))));
            bus.throw_in = 3'($urandom_range(7));
            step();
        end
        checkOutput("arm_no_roll", int'(bus.roll_en), 0);
        setButtons(1'b0, 1'(($urandom_range(1))));
        step();
        checkOutput("press_no_roll", int'(bus.roll_en), 0);
        setButtons(1'b1, 1'(($urandom_range(1))));
        step();
        checkOutput("roll_start", int'(bus.roll_en), 1);

        hl       = holdLen;
        attempts = 0;
        rolling  = 1'b1;
        while (rolling) begin
            len = 0;
            while ((bus.roll_en === 1'b1) && (len < 100)) begin
                len++;
                setButtons(1'(len < hl), 1'(($urandom_range(1))));
                bus.throw_in = 3'($urandom_range(7));
                step();
            end
            checkOutput("roll_len", len, (hl > MIN_ROLL) ? hl : MIN_ROLL);

            if ((attempts < 2) && ($urandom_range(3) == 0)) begin
                v = ($urandom_range(1) == 1) ? 7 : 0;
            end else begin
                v = int'($urandom_range(6, 1));
            end
            attempts++;
            bus.throw_in = 3'(v);

            if ((v == 0) || (v == 7)) begin
                setButtons(1'b0, 1'(($urandom_range(1))));
                step();
                checkOutput("reroll_start", int'(bus.roll_en), 1);
                checkOutput("invalid_no_pulse", int'(bus.result_valid), 0);
                checkState("invalid");
                hl = 0;
            end else begin
                setButtons(1'b0, nextHeld);
                step();
                mScore[mTurn] += v;
                mLast = v;
                if (mScore[mTurn] >= TARGET) begin
                    mDone   = 1'b1;
                    mWinner = mTurn;
                end else begin
                    mTurn = ~mTurn;
                end
                checkOutput("result_pulse", int'(bus.result_valid), 1);
                checkOutput("after_capture_roll_en", int'(bus.roll_en), 0);
                checkState("capture");
                setButtons(nextHeld, 1'(($urandom_range(1))));
                step();
                checkOutput("pulse_single", int'(bus.result_valid), 0);
                checkOutput("idle_roll_en", int'(bus.roll_en), 0);
                rolling = 1'b0;
            end
        end
    endtask

    // Play turns until somebody wins, then hammer the buttons while checking the game is frozen
    task automatic playGame(input int firstHold);
        int hold;
        int pre;
        int turns;

        turns   = 0;
        nextPre = 2;
        while (!mDone && (turns < 60)) begin
            hold     = (turns == 0) ? firstHold : int'($urandom_range(20, 1));
            pre      = nextPre;
            nextHeld = 1'(($urandom_range(1)));
            nextPre  = nextHeld ? int'($urandom_range(3, 1)) : 0;
            applyStimulus(hold, pre);
            turns++;
        end
        checkOutput("game_finished", int'(mDone), 1);
        for (int i = 0; i < 10; i++) begin
            bus.btn_a    = 1'(($urandom_range(1)));
            bus.btn_b    = 1'(($urandom_range(1)));
            bus.throw_in = 3'($urandom_range(7));
            step();
            checkOutput("done_roll_en", int'(bus.roll_en), 0);
            checkState("done");
        end
    endtask

    // Reset asserted while the roller is running must stop it and discard the throw
    task automatic midRollReset();
        setButtons(1'b0, 1'b0);
        step();
        setButtons(1'b1, 1'b0);
        bus.throw_in = 3'd3;
        step();
        for (int i = 0; i < 3; i++) begin
            checkOutput("mid_roll_active", int'(bus.roll_en), 1);
            step();
        end
        resetDut();
    endtask

    // Hard time limit so a stuck design still ends the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        bus.btn_a    = 1'b1;
        bus.btn_b    = 1'b0;
        bus.throw_in = 3'd0;
        nextHeld     = 1'b0;
        nextPre      = 0;
        modelReset();
        rst = 1'b1;
        step();
        resetDut();
        playGame(3);
        resetDut();
        midRollReset();
        playGame(20);
        resetDut();
        playGame(int'($urandom_range(20, 1)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
